// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges non-stallable ALU results with FIFO-buffered load returns onto one regfile write port.
// Latency: ALU result 1 cycle; a load pops no earlier than the edge after it is accepted (no bypass).
// Backpressure: memReady drops when the load FIFO is full; optional flush via `define WB_FLUSH_EN.
module writeback_arbiter #(
  parameter int WordLen   = 32,
  parameter int WordCount = 16,
  parameter int FifoDepth = 4,
  localparam int Bits     = $clog2(WordCount)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef WB_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 aluValid,
  input  logic [Bits-1:0]      aluReg,
  input  logic [WordLen-1:0]   aluData,
  input  logic                 memValid,
  output logic                 memReady,
  input  logic [Bits-1:0]      memReg,
  input  logic [WordLen-1:0]   memData,
  output logic                 regWrite,
  output logic [Bits-1:0]      writeRegister,
  output logic [WordLen-1:0]   writeData,
  output logic [WordCount-1:0] busyMask
);

  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  logic [Bits-1:0]    ent_reg_q  [FifoDepth];
  logic [WordLen-1:0] ent_data_q [FifoDepth];
  logic [FifoDepth-1:0] live_q, live_d;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 flush_w, push, pop, wr_d;

`ifdef WB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign memReady = (count_q != CW'(FifoDepth));
  // A flush swallows any push and any pop of that cycle; the ALU slot is unaffected.
  assign push     = memValid & memReady & ~flush_w;
  assign pop      = ~aluValid & (count_q != '0) & ~flush_w;
  assign wr_d     = aluValid | (pop & live_q[head_q]);

  // Next FIFO state: kill by younger ALU write (including same-edge push), pop, push, flush.
  always_comb begin
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    for (int i = 0; i < FifoDepth; i++) begin
      if (aluValid && ent_reg_q[i] == aluReg) live_d[i] = 1'b0;
    end
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end
    if (push) begin
      live_d[tail_q] = ~(aluValid && memReg == aluReg);
      tail_d         = tail_q + 1'b1;
    end
    if (flush_w) begin
      live_d  = '0;
      count_d = '0;
      head_d  = tail_q;
    end
  end

  // Control state and registered write port, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else begin
      live_q   <= live_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      regWrite <= wr_d;
      if (wr_d) begin
        writeRegister <= aluValid ? aluReg  : ent_reg_q[head_q];
        writeData     <= aluValid ? aluData : ent_data_q[head_q];
      end
    end
  end

  // Entry payload storage; validity is carried only by live_q so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[tail_q]  <= memReg;
      ent_data_q[tail_q] <= memData;
    end
  end

  // Busy mask: one bit per register targeted by a still-live queued load.
  always_comb begin
    busyMask = '0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (live_q[i]) busyMask[ent_reg_q[i]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic against a queue-based model.
// Latency: model outputs are the expected values after each posedge, compared on every negedge.
// Backpressure: model accepts a load only when its queue holds fewer than FifoDepth entries.
module tb_writeback_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        aluValid = 1'b0;
  logic [3:0]  aluReg = '0;
  logic [31:0] aluData = '0;
  logic        memValid = 1'b0;
  logic        memReady;
  logic [3:0]  memReg = '0;
  logic [31:0] memData = '0;
  logic        regWrite;
  logic [3:0]  writeRegister;
  logic [31:0] writeData;
  logic [15:0] busyMask;
`ifdef WB_FLUSH_EN
  logic        flush = 1'b0;
`endif

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
`ifdef WB_FLUSH_EN
    .flush(flush),
`endif
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .busyMask(busyMask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        q[$];
  logic        m_wr = 1'b0;
  logic [3:0]  m_reg = '0;
  logic [31:0] m_data = '0;
  int          errors = 0;
  int          checks = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_busy();
    logic [15:0] b = '0;
    foreach (q[i]) if (q[i].live) b[q[i].r] = 1'b1;
    return b;
  endfunction

  // Advance the model by one edge using the inputs that were held across it.
  task automatic model_step();
    bit   ready;
    ent_t e;
    ready = (q.size() != DEPTH);
    if (aluValid) begin
      m_wr = 1'b1; m_reg = aluReg; m_data = aluData;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_wr = e.live;
      if (e.live) begin m_reg = e.r; m_data = e.d; end
    end else begin
      m_wr = 1'b0;
    end
    if (memValid && ready) q.push_back('{r: memReg, d: memData, live: 1'b1});
    if (aluValid) foreach (q[i]) if (q[i].r == aluReg) q[i].live = 1'b0;
  endtask

  // Every negedge the DUT must agree with the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("regWrite", {31'd0, regWrite}, {31'd0, m_wr});
      if (m_wr) begin
        chk("writeRegister", {28'd0, writeRegister}, {28'd0, m_reg});
        chk("writeData", writeData, m_data);
      end
      chk("busyMask", {16'd0, busyMask}, {16'd0, model_busy()});
      chk("memReady", {31'd0, memReady}, {31'd0, (q.size() != DEPTH)});
    end
  end

  // Called at posedge+1; drives inputs for the coming edge, then steps the model after it.
  task automatic cycle(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [3:0] mr, input logic [31:0] md);
    aluValid = av; aluReg = ar; aluData = ad;
    memValid = mv; memReg = mr; memData = md;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    q.delete();
    m_wr = 1'b0; m_reg = '0; m_data = '0;
    chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
    chk("rst_writeRegister", {28'd0, writeRegister}, 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_busyMask", {16'd0, busyMask}, 32'd0);
    chk("rst_memReady", {31'd0, memReady}, 32'd1);
    aluValid = 1'b0; memValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_step();
  endtask

  initial begin
    #1;
    chk_en = 1'b1;
    do_reset();

    // ALU path
    cycle(1, 4'd5, 32'hDEAD_BEEF, 0, 0, 0);
    chk("alu_wr", {31'd0, regWrite}, 32'd1);
    chk("alu_reg", {28'd0, writeRegister}, 32'd5);
    chk("alu_data", writeData, 32'hDEAD_BEEF);
    chk("alu_fifo", {16'd0, busyMask}, 32'd0);

    // Load drain: queue r3, r4 behind ALU traffic to r9, then drain
    cycle(1, 4'd9, 32'h9, 1, 4'd3, 32'h11);
    cycle(1, 4'd9, 32'h9, 1, 4'd4, 32'h22);
    chk("drain_busy0", {16'd0, busyMask}, 32'h18);
    cycle(0, 0, 0, 0, 0, 0);
    chk("drain_r3", {28'd0, writeRegister}, 32'd3);
    chk("drain_d3", writeData, 32'h11);
    chk("drain_busy1", {16'd0, busyMask}, 32'h10);
    cycle(0, 0, 0, 0, 0, 0);
    chk("drain_r4", {28'd0, writeRegister}, 32'd4);
    chk("drain_d4", writeData, 32'h22);
    chk("drain_busy2", {16'd0, busyMask}, 32'h0);

    // Full / back-pressure
    for (int r = 8; r < 12; r++) cycle(1, 4'd1, 32'h100, 1, 4'(r), 32'(r * 'h101));
    chk("full_ready", {31'd0, memReady}, 32'd0);
    chk("full_busy", {16'd0, busyMask}, 32'h0F00);
    cycle(1, 4'd1, 32'h104, 1, 4'd12, 32'hC0C);
    chk("full_held", {16'd0, busyMask}, 32'h0F00);
    cycle(0, 0, 0, 1, 4'd12, 32'hC0C);
    chk("full_pop_r8", {28'd0, writeRegister}, 32'd8);
    chk("full_ready_after_pop", {31'd0, memReady}, 32'd1);
    cycle(0, 0, 0, 1, 4'd12, 32'hC0C);
    chk("full_pop_r9", {28'd0, writeRegister}, 32'd9);
    cycle(0, 0, 0, 0, 0, 0);
    chk("full_pop_r10", {28'd0, writeRegister}, 32'd10);
    cycle(0, 0, 0, 0, 0, 0);
    chk("full_pop_r11", {28'd0, writeRegister}, 32'd11);
    cycle(0, 0, 0, 0, 0, 0);
    chk("full_pop_r12", {28'd0, writeRegister}, 32'd12);
    chk("full_pop_d12", writeData, 32'hC0C);

    // Kill by younger ALU write
    cycle(1, 4'd1, 32'h1, 1, 4'd7, 32'h77);
    chk("kill_busy_set", {16'd0, busyMask}, 32'h80);
    cycle(1, 4'd7, 32'h99, 0, 0, 0);
    chk("kill_alu_data", writeData, 32'h99);
    chk("kill_busy_clear", {16'd0, busyMask}, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("kill_slot_nowrite", {31'd0, regWrite}, 32'd0);
    chk("kill_slot_keep", writeData, 32'h99);

    // Same-edge kill
    cycle(1, 4'd2, 32'hAA, 1, 4'd2, 32'h22);
    chk("same_kill_busy", {16'd0, busyMask}, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("same_kill_nowrite", {31'd0, regWrite}, 32'd0);

    // Mid-traffic reset with three queued loads
    for (int r = 1; r < 4; r++) cycle(1, 4'd15, 32'hF, 1, 4'(r), 32'(r));
    chk("pre_rst_busy", {16'd0, busyMask}, 32'h0E);
    do_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle(($urandom_range(0, 9) < 4), 4'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 9) < 6), 4'($urandom_range(0, 7)), $urandom());
    end
    cycle(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
